// File: rtl/mult_12_arbiter_if.sv
// Handshake and result bus between requesters, the shared multiplier and mult_12_arbiter.
// The arbiter takes the slave side; the requester/multiplier environment takes the master side.
interface mult_12_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [12*NUM_REQ-1:0] req_data_a_i;
    logic [12*NUM_REQ-1:0] req_data_b_i;
    logic [11:0]           mult_data_1_o;
    logic [11:0]           mult_data_2_o;
    logic [11:0]           mult_result_i;
    logic                  res_valid_o;
    logic [ID_W-1:0]       res_id_o;
    logic [11:0]           res_data_o;
    logic                  busy_o;

    modport master (
        output req_valid_i, req_data_a_i, req_data_b_i, mult_result_i,
        input  req_ready_o, mult_data_1_o, mult_data_2_o,
               res_valid_o, res_id_o, res_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_data_a_i, req_data_b_i, mult_result_i,
        output req_ready_o, mult_data_1_o, mult_data_2_o,
               res_valid_o, res_id_o, res_data_o, busy_o
    );
endinterface

// File: rtl/mult_12_arbiter.sv
// Round-robin arbiter sharing one pipelined 12-bit float multiplier between NUM_REQ requesters.
// Requester ids travel through a tag pipeline aligned with the multiplier latency.
module mult_12_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MULT_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mult_12_arbiter_if.slave bus
);
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [11:0]        mult_data_1_q, mult_data_1_d;
    logic [11:0]        mult_data_2_q, mult_data_2_d;
    logic [MULT_LAT:0]  tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [MULT_LAT+1];
    logic [ID_W-1:0]    tag_id_d [MULT_LAT+1];
    logic               busy_q, busy_d;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] ready_oh;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= 32'(NUM_REQ)) sum = sum - 32'(NUM_REQ);
        return sum[ID_W-1:0];
    endfunction

    // Search starts just past the last winner so a held request waits its turn.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        if (!rst_i) begin
            for (int unsigned i = 1; i <= NUM_REQ; i++) begin
                if (!grant_any && bus.req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
                    grant_any = 1'b1;
                    grant_id  = wrap_idx(rr_ptr_q, i);
                end
            end
        end
    end

    always_comb begin
        ready_oh      = '0;
        mult_data_1_d = 12'h000;
        mult_data_2_d = 12'h000;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_any && grant_id == ID_W'(k)) begin
                ready_oh[k]   = 1'b1;
                mult_data_1_d = bus.req_data_a_i[12*k +: 12];
                mult_data_2_d = bus.req_data_b_i[12*k +: 12];
            end
        end
        rr_ptr_d = grant_any ? grant_id : rr_ptr_q;
    end

    // busy reflects the tag bits as they will stand after this edge, so the final
    // result cycle is the last busy cycle.
    always_comb begin
        tag_vld_d   = {tag_vld_q[MULT_LAT-1:0], grant_any};
        tag_id_d[0] = grant_id;
        for (int s = 1; s <= MULT_LAT; s++) begin
            tag_id_d[s] = tag_id_q[s-1];
        end
        busy_d = grant_any | (|tag_vld_q[MULT_LAT-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q      <= ID_W'(NUM_REQ-1);
            mult_data_1_q <= 12'h000;
            mult_data_2_q <= 12'h000;
            tag_vld_q     <= '0;
            busy_q        <= 1'b0;
            for (int s = 0; s <= MULT_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            mult_data_1_q <= mult_data_1_d;
            mult_data_2_q <= mult_data_2_d;
            tag_vld_q     <= tag_vld_d;
            busy_q        <= busy_d;
            tag_id_q      <= tag_id_d;
        end
    end

    assign bus.req_ready_o   = ready_oh;
    assign bus.mult_data_1_o = mult_data_1_q;
    assign bus.mult_data_2_o = mult_data_2_q;
    assign bus.res_valid_o   = tag_vld_q[MULT_LAT];
    assign bus.res_id_o      = tag_id_q[MULT_LAT];
    assign bus.res_data_o    = bus.mult_result_i;
    assign bus.busy_o        = busy_q;
endmodule
